// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide engine: op and state encodings.
// The optional single-cycle multiply path is enabled by MULT_DIV_FAST_MULT_EN.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_t;

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_t op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/busy/done handshake between the EX stage and the multiply/divide engine.
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      start;
    logic                      flush;
    logic [1:0]                op;
    logic [DATA_WIDTH-1:0]     operand_1;
    logic [DATA_WIDTH-1:0]     operand_2;
    logic                      busy;
    logic                      done;
    logic [2*DATA_WIDTH-1:0]   result;

    modport master (
        output start, flush, op, operand_1, operand_2,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, operand_1, operand_2,
        output busy, done, result
    );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// One combinational restoring-divide iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module mult_div_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic                  dividend_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic                  q_bit
);
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    // rem < divisor, so shifted < 2*divisor and the top bit of diff is a true sign
    assign shifted  = {rem, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[DATA_WIDTH];
    assign rem_next = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide engine (shift-add multiply, restoring divide).
// Define MULT_DIV_FAST_MULT_EN for a single-cycle MULT/MULTU path.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    md_state_t        state;
    logic             is_div_q;
    logic             sign_a;
    logic             sign_b;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    logic [2*W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [2*W-1:0]   result_q;

    md_op_t           op_in;
    logic             in_signed;
    logic             neg_1;
    logic             neg_2;
    logic [W-1:0]     abs_1;
    logic [W-1:0]     abs_2;

    assign op_in     = md_op_t'(bus.op);
    assign in_signed = op_is_signed(op_in);
    assign neg_1     = in_signed & bus.operand_1[W-1];
    assign neg_2     = in_signed & bus.operand_2[W-1];
    assign abs_1     = neg_1 ? -bus.operand_1 : bus.operand_1;
    assign abs_2     = neg_2 ? -bus.operand_2 : bus.operand_2;

    // Multiply: multiplier sits in acc low half and is consumed LSB first while
    // partial sums accumulate in the high half and shift right.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opa : {W{1'b0}})};
    assign mul_next = {mul_sum, acc[W-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [W-1:0]   rem_next;
    logic           q_bit;
    logic [2*W-1:0] div_next;

    mult_div_div_step #(
        .DATA_WIDTH(W)
    ) u_div_step (
        .rem          (acc[2*W-1:W]),
        .dividend_bit (acc[W-1]),
        .divisor      (opb),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    assign div_next = {rem_next, acc[W-2:0], q_bit};

    logic [W-1:0]   q_abs;
    logic [W-1:0]   r_abs;
    logic [W-1:0]   raw_a;
    logic [2*W-1:0] fix_result;

    assign q_abs = acc[W-1:0];
    assign r_abs = acc[2*W-1:W];
    assign raw_a = sign_a ? -opa : opa;

    always_comb begin
        fix_result = '0;
        if (is_div_q) begin
            if (opb == '0) begin
                fix_result = {raw_a, {W{1'b1}}};
            end else begin
                fix_result = {(sign_a ? -r_abs : r_abs), ((sign_a ^ sign_b) ? -q_abs : q_abs)};
            end
        end else begin
            fix_result = (sign_a ^ sign_b) ? -acc : acc;
        end
    end

    logic           fast_accept;
    logic [2*W-1:0] fast_prod;
`ifdef MULT_DIV_FAST_MULT_EN
    logic [2*W-1:0] ext_1;
    logic [2*W-1:0] ext_2;
    assign ext_1       = {{W{neg_1}}, bus.operand_1};
    assign ext_2       = {{W{neg_2}}, bus.operand_2};
    assign fast_accept = ~op_is_div(op_in);
    assign fast_prod   = ext_1 * ext_2;
`else
    assign fast_accept = 1'b0;
    assign fast_prod   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MD_IDLE;
            is_div_q <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            state  <= MD_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (bus.start) begin
                        is_div_q <= op_is_div(op_in);
                        sign_a   <= neg_1;
                        sign_b   <= neg_2;
                        opa      <= abs_1;
                        opb      <= abs_2;
                        acc      <= {{W{1'b0}}, (op_is_div(op_in) ? abs_1 : abs_2)};
                        cnt      <= '0;
                        if (fast_accept) begin
                            result_q <= fast_prod;
                            done_q   <= 1'b1;
                            state    <= MD_DONE;
                        end else begin
                            busy_q <= 1'b1;
                            state  <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    acc <= is_div_q ? div_next : mul_next;
                    if (cnt == CNT_W'(W - 1)) begin
                        state <= MD_FIX;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MD_FIX: begin
                    result_q <= fix_result;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state    <= MD_DONE;
                end
                MD_DONE: begin
                    done_q <= 1'b0;
                    state  <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    // A flush arriving in the DONE cycle must still hide the pulse from EX.
    assign bus.busy   = busy_q;
    assign bus.done   = done_q & ~bus.flush;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int W   = 32;
    localparam int LAT = W + 2;
`ifdef MULT_DIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    mult_div_unit_if #(.DATA_WIDTH(W)) bus ();

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_fn(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return 64'(ux * uy);
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                sq = sx / sy; sr = sx % sy;
                qv = sq; rv = sr;
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy; ur = ux % uy;
                qv = uq; rv = ur;
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    // Reference: an accepted op occupies LAT-1 busy cycles, then a done pulse.
    int          m_wait = 0;
    logic        m_done = 1'b0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (bus.flush) begin
            m_wait <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_wait > 0) begin
            if (m_wait == 1) begin
                m_res  <= m_pend;
                m_done <= 1'b1;
            end
            m_wait <= m_wait - 1;
        end else if (bus.start) begin
            if (FAST && !bus.op[1]) begin
                m_res  <= ref_fn(bus.op, bus.operand_1, bus.operand_2);
                m_done <= 1'b1;
            end else begin
                m_pend <= ref_fn(bus.op, bus.operand_1, bus.operand_2);
                m_wait <= LAT - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy",   bus.busy,   (m_wait > 0));
        check("done",   bus.done,   m_done & ~bus.flush);
        check("result", bus.result, m_res);
    end

    logic [63:0] last_res = '0;

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp_r);
        int          c0;
        int          lat;
        bit          seen;
        logic [63:0] res;
        @(posedge clk); #2;
        bus.op = o; bus.operand_1 = x; bus.operand_2 = y; bus.start = 1'b1;
        c0 = cyc;
        @(posedge clk); #2;
        bus.start = 1'b0;
        seen = 1'b0; lat = 0; res = '0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc - c0;
                res  = bus.result;
            end
        end
        check({name, "_seen"},   seen, 1'b1);
        check({name, "_lat"},    lat, ((FAST && !o[1]) ? 1 : LAT));
        check({name, "_result"}, res, exp_r);
        last_res = exp_r;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          c0;
        int          ndone;
        int          d1, d2;
        logic [63:0] prev;
        logic [1:0]  fl_op;

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
        bus.operand_1 = '0; bus.operand_2 = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_busy",   bus.busy,   1'b0);
        check("reset_done",   bus.done,   1'b0);
        check("reset_result", bus.result, 64'h0);
        @(posedge clk); #2 rst = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("divu_zero", 2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF);
        run_op("div_zero",  2'b10, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF);

        // Flush mid-operation, then a fresh start two cycles later.
        prev  = last_res;
        fl_op = FAST ? 2'b11 : 2'b01;
        @(posedge clk); #2;
        bus.op = fl_op; bus.operand_1 = 32'h1234; bus.operand_2 = 32'h56; bus.start = 1'b1;
        c0 = cyc;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #2; end
        check("flush_cycle", cyc - c0, 10);
        bus.flush = 1'b1;
        @(posedge clk); #2 bus.flush = 1'b0;
        check("flush_busy",   bus.busy,   1'b0);
        check("flush_result", bus.result, prev);
        run_op("after_flush", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

        // flush together with start in IDLE: start is dropped.
        @(posedge clk); #2;
        bus.op = 2'b11; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_busy", bus.busy, 1'b0);

        // flush in the DONE cycle suppresses the pulse.
        @(posedge clk); #2;
        bus.op = 2'b11; bus.operand_1 = 32'd50; bus.operand_2 = 32'd6; bus.start = 1'b1;
        c0 = cyc;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #2; end
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_done_pulse", bus.done, 1'b0);
        check("flush_done_res",   bus.result, 64'h0000_0002_0000_0008);
        @(posedge clk); #2 bus.flush = 1'b0;

        // start held high: exactly one done per op, back to back.
        @(posedge clk); #2;
        bus.op = 2'b11; bus.operand_1 = 32'd1000; bus.operand_2 = 32'd10; bus.start = 1'b1;
        ndone = 0; d1 = 0; d2 = 0;
        for (int i = 1; i <= 75; i++) begin
            @(posedge clk); #2;
            if (i == 36) bus.start = 1'b0;
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (ndone == 1) d1 = i;
                if (ndone == 2) d2 = i;
            end
        end
        check("b2b_count",  ndone, 2);
        check("b2b_first",  d1, LAT);
        check("b2b_second", d2, 2 * LAT + 1);
        check("b2b_result", bus.result, 64'h0000_0000_0000_0064);

        // Asynchronous reset mid-CALC.
        @(posedge clk); #2;
        bus.op = 2'b01; bus.operand_1 = 32'd3; bus.operand_2 = 32'd9; bus.start = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (5) begin @(posedge clk); end
        #2 rst = 1'b1;
        #1;
        check("rst_busy",   bus.busy,   1'b0);
        check("rst_done",   bus.done,   1'b0);
        check("rst_result", bus.result, 64'h0);
        @(posedge clk); #2 rst = 1'b0;

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #2;
            bus.start     = ($urandom_range(0, 2) == 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            bus.op        = 2'($urandom_range(0, 3));
            bus.operand_1 = pick();
            bus.operand_2 = pick();
        end
        @(posedge clk); #2;
        bus.start = 1'b0; bus.flush = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
